// File: rtl/opl3_pkg.sv
// Shared OPL3 definitions: timer register map, control-bit positions and timer state type.
package opl3_pkg;

  localparam int REG_TIMER_WIDTH = 8;

  localparam logic [7:0] TIMER1_ADDR     = 8'h02;
  localparam logic [7:0] TIMER2_ADDR     = 8'h03;
  localparam logic [7:0] TIMER_CTRL_ADDR = 8'h04;

  localparam int CTRL_RST_BIT = 7;
  localparam int CTRL_MT1_BIT = 6;
  localparam int CTRL_MT2_BIT = 5;
  localparam int CTRL_ST2_BIT = 1;
  localparam int CTRL_ST1_BIT = 0;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/opl3_timer_channel.sv
// One OPL3 timer: IDLE/RUN sequencing, sample-tick prescaler, up-counter with reload.
// overflow is a combinational pulse in the cycle the counter wraps past 0xFF.
module opl3_timer_channel
  import opl3_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_clk_en,
  input  logic                       start,
  input  logic                       force_reload,
  input  logic [REG_TIMER_WIDTH-1:0] tl,
  output logic                       overflow
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [REG_TIMER_WIDTH-1:0] CNT_MAX = '1;

  timer_state_e               state_q, state_d;
  logic [PW-1:0]              presc_q, presc_d;
  logic [REG_TIMER_WIDTH-1:0] cnt_q, cnt_d;
  logic                       tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TMR_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Loading on start swallows any sample tick in the same cycle; stop freezes the count.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cnt_d    = cnt_q;
    tick     = 1'b0;
    overflow = 1'b0;
    case (state_q)
      TMR_IDLE: begin
        presc_d = '0;
        if (start) begin
          state_d = TMR_RUN;
          cnt_d   = tl;
        end
      end
      TMR_RUN: begin
        if (!start) begin
          state_d = TMR_IDLE;
          presc_d = '0;
        end else begin
          if (sample_clk_en) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              tick    = 1'b1;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
          if (tick) begin
            if (cnt_q == CNT_MAX) begin
              overflow = 1'b1;
              cnt_d    = tl;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (force_reload) begin
            cnt_d = tl;
          end
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

endmodule

// File: rtl/opl3_timer_ctrl.sv
// OPL3 Timer 1/2 controller: register decode, masks, flags and registered IRQ.
// Define OPL3_TRICK_SW_OVERRIDE_EN to let force_timer_overflow act as a Timer 1 overflow.
module opl3_timer_ctrl
  import opl3_pkg::*;
#(
  parameter int TIMER1_PRESCALE = 4,
  parameter int TIMER2_PRESCALE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_clk_en,
  input  logic       reg_wr_valid,
  input  logic       reg_wr_bank,
  input  logic [7:0] reg_wr_addr,
  input  logic [7:0] reg_wr_data,
  input  logic       force_timer_overflow,
  output logic [2:0] status_flags,
  output logic       irq_n
);

  logic [REG_TIMER_WIDTH-1:0] tl1_q, tl2_q;
  logic mt1_q, mt2_q, st1_q, st2_q, ft1_q, ft2_q;
  logic bank0_wr, rst_wr;
  logic ovf1, ovf2, force_edge, set_ft1, set_ft2;

  assign bank0_wr = reg_wr_valid && !reg_wr_bank;
  assign rst_wr   = bank0_wr && (reg_wr_addr == TIMER_CTRL_ADDR) && reg_wr_data[CTRL_RST_BIT];

`ifdef OPL3_TRICK_SW_OVERRIDE_EN
  logic force_q;

  always_ff @(posedge clk) begin
    if (reset) force_q <= 1'b0;
    else       force_q <= force_timer_overflow;
  end

  assign force_edge = force_timer_overflow && !force_q;
`else
  logic unused_force;

  assign unused_force = force_timer_overflow;
  assign force_edge   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tl1_q <= '0;
      tl2_q <= '0;
      mt1_q <= 1'b0;
      mt2_q <= 1'b0;
      st1_q <= 1'b0;
      st2_q <= 1'b0;
    end else if (bank0_wr) begin
      case (reg_wr_addr)
        TIMER1_ADDR: tl1_q <= reg_wr_data;
        TIMER2_ADDR: tl2_q <= reg_wr_data;
        TIMER_CTRL_ADDR: begin
          if (!reg_wr_data[CTRL_RST_BIT]) begin
            mt1_q <= reg_wr_data[CTRL_MT1_BIT];
            mt2_q <= reg_wr_data[CTRL_MT2_BIT];
            st1_q <= reg_wr_data[CTRL_ST1_BIT];
            st2_q <= reg_wr_data[CTRL_ST2_BIT];
          end
        end
        default: ;
      endcase
    end
  end

  opl3_timer_channel #(.PRESCALE(TIMER1_PRESCALE)) u_timer1 (
    .clk          (clk),
    .reset        (reset),
    .sample_clk_en(sample_clk_en),
    .start        (st1_q),
    .force_reload (force_edge),
    .tl           (tl1_q),
    .overflow     (ovf1)
  );

  opl3_timer_channel #(.PRESCALE(TIMER2_PRESCALE)) u_timer2 (
    .clk          (clk),
    .reset        (reset),
    .sample_clk_en(sample_clk_en),
    .start        (st2_q),
    .force_reload (1'b0),
    .tl           (tl2_q),
    .overflow     (ovf2)
  );

  assign set_ft1 = (ovf1 || force_edge) && !mt1_q;
  assign set_ft2 = ovf2 && !mt2_q;

  // An overflow in the same cycle as an RST write leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ft1_q <= 1'b0;
      ft2_q <= 1'b0;
    end else begin
      if (set_ft1)     ft1_q <= 1'b1;
      else if (rst_wr) ft1_q <= 1'b0;
      if (set_ft2)     ft2_q <= 1'b1;
      else if (rst_wr) ft2_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_flags <= 3'b000;
      irq_n        <= 1'b1;
    end else begin
      status_flags <= {ft1_q || ft2_q, ft1_q, ft2_q};
      irq_n        <= !(ft1_q || ft2_q);
    end
  end

endmodule

// File: tb/tb_opl3_timer_ctrl.sv
// Bench for opl3_timer_ctrl: directed steps then random traffic against a tick-countdown model.
// Honours OPL3_TRICK_SW_OVERRIDE_EN the same way as the design build.
module tb_opl3_timer_ctrl;

  localparam int P1 = 4;
  localparam int P2 = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_clk_en = 1'b0;
  logic       reg_wr_valid = 1'b0;
  logic       reg_wr_bank = 1'b0;
  logic [7:0] reg_wr_addr = 8'h00;
  logic [7:0] reg_wr_data = 8'h00;
  logic       force_timer_overflow = 1'b0;
  logic [2:0] status_flags;
  logic       irq_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per timer, the number of sample ticks left until the next overflow.
  int   m_tl[2];
  bit   m_mt[2], m_st[2], m_run[2], m_ft[2];
  int   m_left[2];
  logic [2:0] m_flags;
  logic m_irqn;
  bit   m_force_prev;

  always #5 clk = ~clk;

  opl3_timer_ctrl #(.TIMER1_PRESCALE(P1), .TIMER2_PRESCALE(P2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .sample_clk_en       (sample_clk_en),
    .reg_wr_valid        (reg_wr_valid),
    .reg_wr_bank         (reg_wr_bank),
    .reg_wr_addr         (reg_wr_addr),
    .reg_wr_data         (reg_wr_data),
    .force_timer_overflow(force_timer_overflow),
    .status_flags        (status_flags),
    .irq_n               (irq_n)
  );

  function automatic int reloadTicks(input int tl, input int p);
    return (256 - tl) * p;
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] exp_flags, input logic exp_irqn);
    n_checks++;
    assert (status_flags === exp_flags) else begin
      n_fail++;
      $display("[TB] FAIL %s status_flags got %b expected %b", tag, status_flags, exp_flags);
      $error("[TB] check %s status_flags wrong", tag);
    end
    n_checks++;
    assert (irq_n === exp_irqn) else begin
      n_fail++;
      $display("[TB] FAIL %s irq_n got %b expected %b", tag, irq_n, exp_irqn);
      $error("[TB] check %s irq_n wrong", tag);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    int  p[2];
    bit  ovf[2];
    bit  act[2];
    bit  fe, rstw;
    int  presc;
    p[0] = P1;
    p[1] = P2;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_tl[i] = 0; m_mt[i] = 0; m_st[i] = 0; m_run[i] = 0; m_ft[i] = 0; m_left[i] = 0;
      end
      m_flags = 3'b000;
      m_irqn = 1'b1;
      m_force_prev = 0;
      return;
    end
    fe = 0;
`ifdef OPL3_TRICK_SW_OVERRIDE_EN
    fe = force_timer_overflow && !m_force_prev;
`endif
    m_force_prev = force_timer_overflow;
    for (int i = 0; i < 2; i++) begin
      ovf[i] = 0;
      act[i] = m_run[i] && m_st[i];
      if (!m_run[i] && m_st[i]) begin
        m_run[i] = 1;
        m_left[i] = reloadTicks(m_tl[i], p[i]);
      end else if (m_run[i] && !m_st[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] && sample_clk_en) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          ovf[i] = 1;
          m_left[i] = reloadTicks(m_tl[i], p[i]);
        end
      end
    end
    if (fe && act[0]) begin
      presc = (p[0] - (m_left[0] % p[0])) % p[0];
      m_left[0] = reloadTicks(m_tl[0], p[0]) - presc;
    end
    m_flags = {m_ft[0] | m_ft[1], m_ft[0], m_ft[1]};
    m_irqn = !(m_ft[0] | m_ft[1]);
    rstw = reg_wr_valid && !reg_wr_bank && reg_wr_addr == 8'h04 && reg_wr_data[7];
    for (int i = 0; i < 2; i++) begin
      if ((ovf[i] || (i == 0 && fe)) && !m_mt[i]) m_ft[i] = 1;
      else if (rstw) m_ft[i] = 0;
    end
    if (reg_wr_valid && !reg_wr_bank) begin
      if (reg_wr_addr == 8'h02) m_tl[0] = int'(reg_wr_data);
      if (reg_wr_addr == 8'h03) m_tl[1] = int'(reg_wr_data);
      if (reg_wr_addr == 8'h04 && !reg_wr_data[7]) begin
        m_mt[0] = reg_wr_data[6];
        m_mt[1] = reg_wr_data[5];
        m_st[1] = reg_wr_data[1];
        m_st[0] = reg_wr_data[0];
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic sce, input logic wv, input logic bank,
                               input logic [7:0] a, input logic [7:0] d, input logic frc,
                               input string tag);
    reset = rst;
    sample_clk_en = sce;
    reg_wr_valid = wv;
    reg_wr_bank = bank;
    reg_wr_addr = a;
    reg_wr_data = d;
    force_timer_overflow = frc;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag, m_flags, m_irqn);
    reset = 1'b0;
    sample_clk_en = 1'b0;
    reg_wr_valid = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, a, d, 1'b0, "write");
  endtask

  task automatic tick(input int n);
    repeat (n) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "tick");
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "idle");
  endtask

  initial begin
    logic [7:0] a, d;
    logic sce, wv, bank, frc, rst;

    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 8'h03, 1'b0, "reset");
    checkOutput("reset_state", 3'b000, 1'b1);
    idle(2);

    // Timer 1 from 0xFE: two counts of four ticks each to overflow.
    wr(8'h02, 8'hFE);
    wr(8'h04, 8'h01);
    idle(1);
    tick(8);
    checkOutput("t1_before_flag", 3'b000, 1'b1);
    idle(1);
    checkOutput("t1_overflow", 3'b110, 1'b0);

    // RST clears the flags while Timer 1 keeps running from the reloaded 0xFE.
    wr(8'h04, 8'h80);
    idle(1);
    checkOutput("rst_clear", 3'b000, 1'b1);
    tick(4);
    checkOutput("t1_reload_mid", 3'b000, 1'b1);
    tick(4);
    idle(1);
    checkOutput("t1_reoverflow", 3'b110, 1'b0);

    // RST on the overflow cycle: overflow wins.
    wr(8'h04, 8'h80);
    idle(1);
    tick(7);
    checkOutput("pre_coincide", 3'b000, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 8'h80, 1'b0, "tick_rst");
    idle(1);
    checkOutput("ovf_beats_rst", 3'b110, 1'b0);

    // Masked Timer 2 never flags; unmasking flags at the next 16-tick boundary.
    wr(8'h04, 8'h80);
    wr(8'h03, 8'hFF);
    wr(8'h04, 8'h22);
    idle(1);
    tick(64);
    idle(1);
    checkOutput("t2_masked", 3'b000, 1'b1);
    wr(8'h04, 8'h02);
    tick(15);
    checkOutput("t2_pre_boundary", 3'b000, 1'b1);
    tick(1);
    idle(1);
    checkOutput("t2_unmasked", 3'b101, 1'b0);

    // Stop freezes Timer 1; restart reloads TL1 and takes (0x100-0xFC)*4 ticks.
    wr(8'h04, 8'h80);
    wr(8'h04, 8'h00);
    idle(1);
    wr(8'h02, 8'hFC);
    wr(8'h04, 8'h01);
    idle(1);
    tick(5);
    wr(8'h04, 8'h00);
    tick(20);
    idle(1);
    checkOutput("t1_frozen", 3'b000, 1'b1);
    wr(8'h04, 8'h01);
    idle(1);
    tick(15);
    idle(1);
    checkOutput("t1_restart_pre", 3'b000, 1'b1);
    tick(1);
    idle(1);
    checkOutput("t1_restart_ovf", 3'b110, 1'b0);

    // Bank-1 and unrelated writes leave everything alone.
    wr(8'h04, 8'h80);
    idle(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'h00, 1'b0, "bank1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, "other_addr");
    checkOutput("ignored_writes", 3'b000, 1'b1);

    // Trick-software forced overflow on Timer 1.
    wr(8'h04, 8'h00);
    wr(8'h02, 8'h00);
    wr(8'h04, 8'h01);
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, "force");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "force_release");
`ifdef OPL3_TRICK_SW_OVERRIDE_EN
    checkOutput("force_overflow", 3'b110, 1'b0);
`else
    checkOutput("force_ignored", 3'b000, 1'b1);
`endif

    // Random traffic against the model, with one mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      rst  = (i == 2000);
      sce  = ($urandom_range(0, 1) == 1);
      wv   = ($urandom_range(0, 9) == 0);
      bank = ($urandom_range(0, 7) == 0);
      frc  = ($urandom_range(0, 40) == 0);
      case ($urandom_range(0, 7))
        0, 1:    a = 8'h02;
        2, 3:    a = 8'h03;
        4, 5, 6: a = 8'h04;
        default: a = 8'($urandom);
      endcase
      if (a == 8'h04) begin
        d = 8'($urandom);
        d[7] = ($urandom_range(0, 3) == 0);
      end else begin
        d = 8'hE0 | 8'($urandom_range(0, 31));
      end
      applyStimulus(rst, sce, wv, bank, a, d, frc, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
